// File: rtl/branch_predictor_table_if.sv
// Lookup/update bus between the CPU pipeline and branch_predictor_table.
//   master : CPU side (drives ID lookup and MEM resolution, reads prediction)
//   slave  : predictor side
// Signals:
//   in_addr, offset, branch_decode_sig     -> ID-stage lookup request
//   prediction, branch_addr, pred_index    <- lookup result (combinational)
//   branch_mem_sig, upd_index,
//   actual_branch_decision                 -> MEM-stage training strobe
//   miss_count                             <- saturating misprediction count
interface branch_predictor_table_if #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned MISS_W = 16
);
  logic [31:0]       in_addr;
  logic [31:0]       offset;
  logic              branch_decode_sig;
  logic              prediction;
  logic [31:0]       branch_addr;
  logic [IDX_W-1:0]  pred_index;
  logic              branch_mem_sig;
  logic [IDX_W-1:0]  upd_index;
  logic              actual_branch_decision;
  logic [MISS_W-1:0] miss_count;

  modport master (
    output in_addr, offset, branch_decode_sig,
    output branch_mem_sig, upd_index, actual_branch_decision,
    input  prediction, branch_addr, pred_index, miss_count
  );

  modport slave (
    input  in_addr, offset, branch_decode_sig,
    input  branch_mem_sig, upd_index, actual_branch_decision,
    output prediction, branch_addr, pred_index, miss_count
  );
endinterface

// File: rtl/branch_predictor_table.sv
// Table of ENTRIES saturating counters indexed by PC[IDX_W+1:2].
// Lookup in ID is combinational against registered state; training in MEM
// on branch_mem_sig uses only upd_index. A saturating miss counter tracks
// how often the pre-update counter MSB disagreed with the resolved outcome.
// Optional build macro BRANCH_PREDICTOR_GSHARE_EN: XORs a GHR_W-bit global
// history (updated at MEM only) into the lookup index.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high; counters -> INIT_STATE, GHR/miss -> 0
//   ce    : clock enable; 0 freezes all state
//   bus   : branch_predictor_table_if.slave (lookup, update, miss_count)
module branch_predictor_table #(
  parameter int unsigned ENTRIES    = 64,
  parameter int unsigned CTR_W      = 2,
  parameter int unsigned INIT_STATE = 1,
  parameter int unsigned MISS_W     = 16,
  parameter int unsigned GHR_W      = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  branch_predictor_table_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_W-1:0]  CTR_INIT = CTR_W'(INIT_STATE);
  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  if (ENTRIES < 2 || ENTRIES > 1024 || (1 << IDX_W) != ENTRIES) begin : g_bad_entries
    $error("ENTRIES must be a power of two in 2..1024");
  end
  if (CTR_W < 1 || CTR_W > 4 || INIT_STATE >= (1 << CTR_W)) begin : g_bad_ctr
    $error("CTR_W must be 1..4 and INIT_STATE < 2**CTR_W");
  end
  if (GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ghr
    $error("GHR_W must be 1..IDX_W");
  end

  logic [CTR_W-1:0]  ctr [ENTRIES];
  logic [MISS_W-1:0] miss;
  logic [IDX_W-1:0]  pc_index;
  logic [IDX_W-1:0]  lookup_index;
  logic              do_update;
  logic [CTR_W-1:0]  upd_cur;
  logic [CTR_W-1:0]  upd_next;
  logic              mispredict;

  assign pc_index  = bus.in_addr[IDX_W+1:2];
  assign do_update = ce & bus.branch_mem_sig;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  assign lookup_index = pc_index ^ IDX_W'(ghr);

  // History shifts in the resolved outcome at MEM only, never speculatively.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr <= '0;
    end else if (do_update) begin
      ghr <= GHR_W'({ghr, bus.actual_branch_decision});
    end
  end
`else
  assign lookup_index = pc_index;
`endif

  // Lookup reads registered state only, so a same-cycle update to the same
  // entry is not visible until the next cycle.
  assign bus.pred_index  = lookup_index;
  assign bus.prediction  = bus.branch_decode_sig & ctr[lookup_index][CTR_W-1];
  assign bus.branch_addr = bus.in_addr + bus.offset;
  assign bus.miss_count  = miss;

  always_comb begin
    upd_cur    = ctr[bus.upd_index];
    upd_next   = upd_cur;
    mispredict = upd_cur[CTR_W-1] ^ bus.actual_branch_decision;
    if (bus.actual_branch_decision) begin
      if (upd_cur != CTR_MAX) upd_next = upd_cur + CTR_W'(1);
    end else begin
      if (upd_cur != '0) upd_next = upd_cur - CTR_W'(1);
    end
  end

  // Flop array: async reset clears every entry in one event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (do_update) begin
      ctr[bus.upd_index] <= upd_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss <= '0;
    end else if (do_update && mispredict && miss != MISS_MAX) begin
      miss <= miss + MISS_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor_table.sv
module tb_branch_predictor_table;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned MISS_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic ce;
  logic [5:0] ghr_m;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  branch_predictor_table_if #(.IDX_W(IDX_W), .MISS_W(MISS_W)) bus ();

  branch_predictor_table #(
    .ENTRIES   (64),
    .CTR_W     (2),
    .INIT_STATE(1),
    .MISS_W    (MISS_W),
    .GHR_W     (6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One update strobe spanning exactly one rising edge.
  task automatic upd(input logic [5:0] idx, input logic act);
    @(negedge clk);
    bus.upd_index              = idx;
    bus.actual_branch_decision = act;
    bus.branch_mem_sig         = 1'b1;
    @(negedge clk);
    bus.branch_mem_sig = 1'b0;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    if (ce) ghr_m = {ghr_m[4:0], act};
`endif
  endtask

  // Point the lookup at table entry k (accounting for history in gshare builds).
  task automatic look(input logic [5:0] k, input logic [31:0] hi);
    logic [5:0] raw;
    raw = k ^ ghr_m;
    bus.in_addr = hi | {24'h0, raw, 2'b00};
    #1;
  endtask

  initial begin
    ghr_m = '0;
    reset = 1'b1;
    ce    = 1'b1;
    bus.in_addr                = '0;
    bus.offset                 = '0;
    bus.branch_decode_sig      = 1'b0;
    bus.branch_mem_sig         = 1'b0;
    bus.upd_index              = '0;
    bus.actual_branch_decision = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: reset state
    bus.offset = 32'h40;
    bus.branch_decode_sig = 1'b1;
    look(6'd0, 32'h100);
    check("rst_pred", {31'b0, bus.prediction}, 32'd0);
    check("rst_index", {26'b0, bus.pred_index}, 32'd0);
    check("rst_miss", {28'b0, bus.miss_count}, 32'd0);
    check("rst_baddr", bus.branch_addr, 32'h140);

    // 2: train to taken 1->2->3
    upd(6'd0, 1'b1);
    upd(6'd0, 1'b1);
    look(6'd0, 32'h100);
    check("train_pred", {31'b0, bus.prediction}, 32'd1);
    check("train_miss", {28'b0, bus.miss_count}, 32'd1);
    bus.branch_decode_sig = 1'b0;
    #1;
    check("nodecode_pred", {31'b0, bus.prediction}, 32'd0);
    bus.branch_decode_sig = 1'b1;

    // 3: saturation at top, then walk down through 0 and back
    repeat (4) upd(6'd0, 1'b1);
    check("sat_hi_miss", {28'b0, bus.miss_count}, 32'd1);
    upd(6'd0, 1'b0);
    look(6'd0, 32'h100);
    check("dn1_pred", {31'b0, bus.prediction}, 32'd1);
    check("dn1_miss", {28'b0, bus.miss_count}, 32'd2);
    upd(6'd0, 1'b0);
    look(6'd0, 32'h100);
    check("dn2_pred", {31'b0, bus.prediction}, 32'd0);
    check("dn2_miss", {28'b0, bus.miss_count}, 32'd3);
    upd(6'd0, 1'b0);
    upd(6'd0, 1'b0);
    upd(6'd0, 1'b1);
    look(6'd0, 32'h100);
    check("sat_lo_pred", {31'b0, bus.prediction}, 32'd0);
    check("sat_lo_miss", {28'b0, bus.miss_count}, 32'd4);
    upd(6'd0, 1'b1);
    look(6'd0, 32'h100);
    check("sat_lo_up_pred", {31'b0, bus.prediction}, 32'd1);
    check("sat_lo_up_miss", {28'b0, bus.miss_count}, 32'd5);

    // 4: aliasing and target wrap
    look(6'd0, 32'h200);
    check("alias_index", {26'b0, bus.pred_index}, 32'd0);
    check("alias_pred", {31'b0, bus.prediction}, 32'd1);
    bus.in_addr = 32'hFFFF_FFFC;
    bus.offset  = 32'h8;
    #1;
    check("wrap_baddr", bus.branch_addr, 32'h0000_0004);
    check("wrap_index", {26'b0, bus.pred_index}, {26'b0, 6'h3F ^ ghr_m});
    bus.offset = 32'h40;

    // 5: same-cycle lookup/update on index 5, no bypass
    @(negedge clk);
    look(6'd5, 32'h0);
    bus.upd_index              = 6'd5;
    bus.actual_branch_decision = 1'b1;
    bus.branch_mem_sig         = 1'b1;
    #1;
    check("same_cyc_index", {26'b0, bus.pred_index}, 32'd5);
    check("same_cyc_pred", {31'b0, bus.prediction}, 32'd0);
    @(negedge clk);
    bus.branch_mem_sig = 1'b0;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    ghr_m = {ghr_m[4:0], 1'b1};
`endif
    look(6'd5, 32'h0);
    check("next_cyc_pred", {31'b0, bus.prediction}, 32'd1);
    check("next_cyc_miss", {28'b0, bus.miss_count}, 32'd6);

    // ce=0 freezes everything
    ce = 1'b0;
    upd(6'd5, 1'b0);
    ce = 1'b1;
    look(6'd5, 32'h0);
    check("ce0_pred", {31'b0, bus.prediction}, 32'd1);
    check("ce0_miss", {28'b0, bus.miss_count}, 32'd6);

    // back-to-back updates on index 7: 1->2->3, then down to 2
    @(negedge clk);
    bus.upd_index              = 6'd7;
    bus.actual_branch_decision = 1'b1;
    bus.branch_mem_sig         = 1'b1;
    repeat (2) @(negedge clk);
    bus.branch_mem_sig = 1'b0;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    ghr_m = {ghr_m[3:0], 2'b11};
`endif
    upd(6'd7, 1'b0);
    look(6'd7, 32'h0);
    check("b2b_pred", {31'b0, bus.prediction}, 32'd1);
    check("b2b_miss", {28'b0, bus.miss_count}, 32'd8);

    // 6: async reset between edges
    @(negedge clk);
    #2;
    reset = 1'b1;
    ghr_m = '0;
    #1;
    check("async_miss", {28'b0, bus.miss_count}, 32'd0);
    look(6'd0, 32'h100);
    check("async_pred0", {31'b0, bus.prediction}, 32'd0);
    check("async_index0", {26'b0, bus.pred_index}, 32'd0);
    look(6'd7, 32'h0);
    check("async_pred7", {31'b0, bus.prediction}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // history: taken, taken, not-taken
    upd(6'd1, 1'b1);
    upd(6'd2, 1'b1);
    upd(6'd3, 1'b0);
    bus.in_addr = 32'h100;
    #1;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    check("ghr_index", {26'b0, bus.pred_index}, 32'd6);
`else
    check("ghr_index", {26'b0, bus.pred_index}, 32'd0);
`endif
    check("ghr_miss", {28'b0, bus.miss_count}, 32'd2);

    // miss_count saturation at 2^MISS_W-1 with alternating outcomes on index 9
    for (int i = 0; i < 12; i++) upd(6'd9, (i % 2) == 0);
    check("miss_pre_sat", {28'b0, bus.miss_count}, 32'd14);
    for (int i = 0; i < 8; i++) upd(6'd9, (i % 2) == 0);
    check("miss_sat", {28'b0, bus.miss_count}, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
